nanov_spi_arb: RTL

NANOV_SPI_ARB -- requirements
Module: nanov_spi_arb

---
 rtl/nanov_spi_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nanov_spi_arb.sv
// Serial-flash read arbiter: shares one SPI flash between an instruction stream and bounded data loads.
// Define NANOV_SPI_ARB_FAIR_EN for alternating tie-break instead of fixed data-load priority.
module nanov_spi_arb #(
  parameter logic [7:0]  CMD_READ       = 8'h03,
  parameter int unsigned CS_HIGH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req,
  input  logic [23:0] ifetch_addr,
  input  logic        dload_req,
  input  logic [23:0] dload_addr,
  input  logic [1:0]  dload_len,
  output logic        ifetch_gnt,
  output logic        dload_gnt,
  output logic        bit_valid,
  output logic        data_bit,
  output logic        dload_done,
  output logic        spi_select,
  output logic        spi_out,
  input  logic        spi_data_in
);

  localparam int unsigned SH_W  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned GAP_W = 3;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  state_t             state_q, state_nxt;
  logic [SH_W-1:0]    sh_q, sh_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   wcnt_q, wcnt_nxt;
  logic [GAP_W-1:0]   gap_q, gap_nxt;
  logic [1:0]         len_q, len_nxt;
  logic               ta_q, ta_nxt;
  logic               fin_q, fin_nxt;
  logic               ifetch_gnt_nxt, dload_gnt_nxt, bit_valid_nxt, data_bit_nxt;
  logic               dload_done_nxt, spi_select_nxt, spi_out_nxt;
  logic               pick_dl, abandon, last_bit, to_gap;

`ifdef NANOV_SPI_ARB_FAIR_EN
  // Remembers whether the most recent grant went to dload; resets to ifetch-last.
  logic last_dl_q;
  assign pick_dl = dload_req && !(ifetch_req && last_dl_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dl_q <= 1'b0;
    end else if (state_q == IDLE && (ifetch_req || dload_req)) begin
      last_dl_q <= pick_dl;
    end
  end
`else
  assign pick_dl = dload_req;
`endif

  assign abandon  = ifetch_gnt && !ifetch_req;
  assign last_bit = dload_gnt ? (wcnt_q == {len_q, 3'b111})
                              : (wcnt_q == 5'd31 && dload_req);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state_q;
    sh_nxt         = sh_q;
    cnt_nxt        = cnt_q;
    wcnt_nxt       = wcnt_q;
    gap_nxt        = gap_q;
    len_nxt        = len_q;
    ta_nxt         = ta_q;
    fin_nxt        = fin_q;
    ifetch_gnt_nxt = ifetch_gnt;
    dload_gnt_nxt  = dload_gnt;
    spi_select_nxt = spi_select;
    spi_out_nxt    = 1'b0;
    bit_valid_nxt  = 1'b0;
    data_bit_nxt   = 1'b0;
    dload_done_nxt = 1'b0;
    to_gap         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifetch_req || dload_req) begin
          state_nxt      = CMD;
          ifetch_gnt_nxt = !pick_dl;
          dload_gnt_nxt  = pick_dl;
          spi_select_nxt = 1'b0;
          spi_out_nxt    = CMD_READ[7];
          sh_nxt         = {CMD_READ[6:0], (pick_dl ? dload_addr : ifetch_addr), 1'b0};
          len_nxt        = dload_len;
          cnt_nxt        = '0;
          wcnt_nxt       = '0;
          ta_nxt         = 1'b0;
          fin_nxt        = 1'b0;
        end
      end
      CMD, ADDR: begin
        if (abandon) begin
          to_gap = 1'b0 | 1'b1;
        end else if (cnt_q == 5'd31) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          wcnt_nxt  = '0;
          ta_nxt    = 1'b1;
        end else begin
          spi_out_nxt = sh_q[SH_W-1];
          sh_nxt      = {sh_q[SH_W-2:0], 1'b0};
          cnt_nxt     = cnt_q + 5'd1;
          if (cnt_q == 5'd7) state_nxt = ADDR;
        end
      end
      DATA: begin
        // First DATA cycle is the flash turnaround; fin holds DATA while the last bit is shown.
        if (abandon) begin
          to_gap = 1'b1;
        end else if (fin_q) begin
          to_gap         = 1'b1;
          dload_done_nxt = dload_gnt;
        end else if (ta_q) begin
          ta_nxt = 1'b0;
        end else begin
          bit_valid_nxt = 1'b1;
          data_bit_nxt  = spi_data_in;
          wcnt_nxt      = wcnt_q + 5'd1;
          fin_nxt       = last_bit;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_q + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (to_gap) begin
      state_nxt      = GAP;
      spi_select_nxt = 1'b1;
      ifetch_gnt_nxt = 1'b0;
      dload_gnt_nxt  = 1'b0;
      gap_nxt        = '0;
      cnt_nxt        = '0;
      wcnt_nxt       = '0;
      ta_nxt         = 1'b0;
      fin_nxt        = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      gap_q      <= '0;
      len_q      <= '0;
      ta_q       <= 1'b0;
      fin_q      <= 1'b0;
      ifetch_gnt <= 1'b0;
      dload_gnt  <= 1'b0;
      bit_valid  <= 1'b0;
      data_bit   <= 1'b0;
      dload_done <= 1'b0;
      spi_select <= 1'b1;
      spi_out    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      sh_q       <= sh_nxt;
      cnt_q      <= cnt_nxt;
      wcnt_q     <= wcnt_nxt;
      gap_q      <= gap_nxt;
      len_q      <= len_nxt;
      ta_q       <= ta_nxt;
      fin_q      <= fin_nxt;
      ifetch_gnt <= ifetch_gnt_nxt;
      dload_gnt  <= dload_gnt_nxt;
      bit_valid  <= bit_valid_nxt;
      data_bit   <= data_bit_nxt;
      dload_done <= dload_done_nxt;
      spi_select <= spi_select_nxt;
      spi_out    <= spi_out_nxt;
    end
  end

endmodule
